snake_body: RTL and testbench

- Owns the snake's body in the grid game and produces the movement/position interface consumed by the coin logic: head and tail coordinates, per-move shift pulse, and per-cell occupancy query.
- Consumes that logic's point pulse to grow.
- Stores segments in a circular buffer, advances the head at a fixed tick rate with toroidal wrap, and detects self-collision.

---
 rtl/snake_body.sv | 190 +++++++++++++++++++
 tb/tb_snake_body.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body.sv
// Snake body for the grid game: circular segment buffer, tick-paced movement with
// toroidal wrap, growth on coin points, self-collision detection and cell occupancy query.
module snake_body #(
    parameter int H         = 32,
    parameter int V         = 32,
    parameter int MAX_LEN   = 64,
    parameter int START_LEN = 3,
    parameter int TICK_DIV  = 1000000,
    localparam int XW = $clog2(H),
    localparam int YW = $clog2(V),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    dir,
    input  logic          dir_valid,
    input  logic          point,
    input  logic [XW-1:0] query_x,
    input  logic [YW-1:0] query_y,
    output logic          query_hit,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [XW-1:0] tail_x,
    output logic [YW-1:0] tail_y,
    output logic          shift_snake,
    output logic [LW-1:0] length,
    output logic          dead
);

    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_RIGHT = 2'd1;
    localparam logic [1:0] D_DOWN  = 2'd2;
    localparam logic [1:0] D_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DEAD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] tick_cnt;
    logic [1:0]    cur_dir;
    logic [1:0]    next_dir;
    logic          grow_pending;
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [LW-1:0] length_q;
    logic [XW-1:0] seg_x [MAX_LEN];
    logic [YW-1:0] seg_y [MAX_LEN];

    logic          tick_done;
    logic          dir_ok;
    logic [1:0]    move_dir;
    logic          grow;
    logic          can_grow;
    logic [XW-1:0] new_x;
    logic [YW-1:0] new_y;
    logic          collide;
    logic          q_hit;
    logic          do_move;
    logic [PW-1:0] head_ptr_inc;
    logic [PW-1:0] tail_ptr_inc;

    assign head_x      = seg_x[head_ptr];
    assign head_y      = seg_y[head_ptr];
    assign tail_x      = seg_x[tail_ptr];
    assign tail_y      = seg_y[tail_ptr];
    assign length      = length_q;
    assign dead        = (state == S_DEAD);

    assign tick_done    = (state == S_RUN) && (tick_cnt == CW'(TICK_DIV - 1));
    // Opposite directions differ only in bit 1, so a reversal is dir == cur_dir ^ 2.
    assign dir_ok       = dir_valid && (dir != (cur_dir ^ 2'b10));
    assign move_dir     = dir_ok ? dir : next_dir;
    assign grow         = grow_pending | point;
    assign can_grow     = grow && (length_q < LW'(MAX_LEN));
    assign head_ptr_inc = (head_ptr == PW'(MAX_LEN - 1)) ? '0 : head_ptr + PW'(1);
    assign tail_ptr_inc = (tail_ptr == PW'(MAX_LEN - 1)) ? '0 : tail_ptr + PW'(1);

    always_comb begin
        new_x = head_x;
        new_y = head_y;
        case (move_dir)
            D_UP:    new_y = (head_y == '0) ? YW'(V - 1) : head_y - YW'(1);
            D_RIGHT: new_x = (head_x == XW'(H - 1)) ? '0 : head_x + XW'(1);
            D_DOWN:  new_y = (head_y == YW'(V - 1)) ? '0 : head_y + YW'(1);
            D_LEFT:  new_x = (head_x == '0) ? XW'(H - 1) : head_x - XW'(1);
            default: new_x = head_x;
        endcase
    end

    // A slot is live when its distance forward from the tail is below the length;
    // the tail slot is ignored for collision unless it stays put because we grow.
    always_comb begin : scan_p
        int   off;
        logic is_live;
        off     = 0;
        is_live = 1'b0;
        collide = 1'b0;
        q_hit   = 1'b0;
        for (int s = 0; s < MAX_LEN; s++) begin
            off = s - int'(tail_ptr);
            if (off < 0) off = off + MAX_LEN;
            is_live = (off < int'(length_q));
            if (is_live && seg_x[s] == query_x && seg_y[s] == query_y)
                q_hit = 1'b1;
            if (is_live && !(PW'(s) == tail_ptr && !can_grow) &&
                seg_x[s] == new_x && seg_y[s] == new_y)
                collide = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        do_move    = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN: begin
                if (tick_done) begin
                    if (collide) state_next = S_DEAD;
                    else         do_move    = 1'b1;
                end
            end
            S_DEAD:  state_next = S_DEAD;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt     <= '0;
            cur_dir      <= D_RIGHT;
            next_dir     <= D_RIGHT;
            grow_pending <= 1'b0;
            head_ptr     <= PW'(START_LEN - 1);
            tail_ptr     <= '0;
            length_q     <= LW'(START_LEN);
            shift_snake  <= 1'b0;
            query_hit    <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++) begin
                if (k < START_LEN) begin
                    seg_x[k] <= XW'(H / 2 - (START_LEN - 1 - k));
                    seg_y[k] <= YW'(V / 2);
                end else begin
                    seg_x[k] <= '0;
                    seg_y[k] <= '0;
                end
            end
        end else begin
            shift_snake <= do_move;
            query_hit   <= q_hit;

            if (state == S_IDLE && start) tick_cnt <= '0;
            else if (state == S_RUN)      tick_cnt <= tick_done ? '0 : tick_cnt + CW'(1);

            if (state != S_DEAD) begin
                if (do_move) begin
                    cur_dir  <= move_dir;
                    next_dir <= move_dir;
                end else if (dir_ok) begin
                    next_dir <= dir;
                end
            end

            if (do_move)                           grow_pending <= 1'b0;
            else if (point && state != S_DEAD)     grow_pending <= 1'b1;

            // Growing keeps the tail in place; a full buffer overwrites the old tail slot.
            if (do_move) begin
                head_ptr            <= head_ptr_inc;
                seg_x[head_ptr_inc] <= new_x;
                seg_y[head_ptr_inc] <= new_y;
                if (can_grow) length_q <= length_q + LW'(1);
                else          tail_ptr <= tail_ptr_inc;
            end
        end
    end

endmodule

// File: tb/tb_snake_body.sv
// Directed self-checking bench for snake_body with a fast tick (4 cycles per move)
// and a second instance with a 4-entry buffer for length saturation.
module tb_snake_body;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] dir;
    logic       dir_valid;
    logic       point;
    logic [4:0] query_x;
    logic [4:0] query_y;

    logic       query_hit;
    logic [4:0] head_x, head_y, tail_x, tail_y;
    logic       shift_snake;
    logic [6:0] length;
    logic       dead;

    logic       s_query_hit;
    logic [4:0] s_head_x, s_head_y, s_tail_x, s_tail_y;
    logic       s_shift_snake;
    logic [2:0] s_length;
    logic       s_dead;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snake_body #(.TICK_DIV(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .dir_valid(dir_valid),
        .point(point), .query_x(query_x), .query_y(query_y), .query_hit(query_hit),
        .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
        .shift_snake(shift_snake), .length(length), .dead(dead)
    );

    snake_body #(.MAX_LEN(4), .TICK_DIV(4)) u_small (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .dir_valid(dir_valid),
        .point(point), .query_x(query_x), .query_y(query_y), .query_hit(s_query_hit),
        .head_x(s_head_x), .head_y(s_head_y), .tail_x(s_tail_x), .tail_y(s_tail_y),
        .shift_snake(s_shift_snake), .length(s_length), .dead(s_dead)
    );

    task automatic do_reset;
        reset = 1'b0; start = 1'b0; dir = 2'd0; dir_valid = 1'b0; point = 1'b0;
        query_x = 5'd0; query_y = 5'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_move(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (shift_snake) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; dir = 2'd0; dir_valid = 1'b0; point = 1'b0;
        query_x = 5'd0; query_y = 5'd0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (head_x !== 5'd16) begin bad++; $display("FAIL rst_head_x got=%0d want=16", head_x); end
        total++; if (head_y !== 5'd16) begin bad++; $display("FAIL rst_head_y got=%0d want=16", head_y); end
        total++; if (tail_x !== 5'd14) begin bad++; $display("FAIL rst_tail_x got=%0d want=14", tail_x); end
        total++; if (tail_y !== 5'd16) begin bad++; $display("FAIL rst_tail_y got=%0d want=16", tail_y); end
        total++; if (length !== 7'd3) begin bad++; $display("FAIL rst_length got=%0d want=3", length); end
        total++; if (dead !== 1'b0 || shift_snake !== 1'b0 || query_hit !== 1'b0) begin
            bad++; $display("FAIL rst_flags got dead=%b shift=%b hit=%b want 0 0 0", dead, shift_snake, query_hit);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_query;
        do_reset();
        query_x = 5'd15; query_y = 5'd16;
        @(negedge clk);
        total++; if (query_hit !== 1'b1) begin bad++; $display("FAIL query_middle got=%b want=1", query_hit); end
        query_x = 5'd5; query_y = 5'd5;
        @(negedge clk);
        total++; if (query_hit !== 1'b0) begin bad++; $display("FAIL query_empty got=%b want=0", query_hit); end
        query_x = 5'd16; query_y = 5'd16;
        @(negedge clk);
        total++; if (query_hit !== 1'b1) begin bad++; $display("FAIL query_head got=%b want=1", query_hit); end
        query_x = 5'd14; query_y = 5'd16;
        @(negedge clk);
        total++; if (query_hit !== 1'b1) begin bad++; $display("FAIL query_tail got=%b want=1", query_hit); end
    endtask

    task automatic test_run;
        int c;
        do_reset();
        start = 1'b1;
        c = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); c++;
            if (shift_snake) break;
        end
        total++; if (c !== 5) begin bad++; $display("FAIL run_first_latency got=%0d want=5", c); end
        total++; if (head_x !== 5'd17 || tail_x !== 5'd15 || length !== 7'd3) begin
            bad++; $display("FAIL run_move1 got head=%0d tail=%0d len=%0d want 17 15 3", head_x, tail_x, length);
        end
        c = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); c++;
            if (shift_snake) break;
        end
        total++; if (c !== 4) begin bad++; $display("FAIL run_period got=%0d want=4", c); end
        total++; if (head_x !== 5'd18 || head_y !== 5'd16 || tail_x !== 5'd16 || length !== 7'd3) begin
            bad++; $display("FAIL run_move2 got head=%0d,%0d tail=%0d len=%0d want 18,16 16 3", head_x, head_y, tail_x, length);
        end
        query_x = 5'd14; query_y = 5'd16;
        @(negedge clk);
        total++; if (query_hit !== 1'b0) begin bad++; $display("FAIL query_stale got=%b want=0", query_hit); end
        total++; if (shift_snake !== 1'b0) begin bad++; $display("FAIL run_pulse_width got=%b want=0", shift_snake); end
    endtask

    task automatic test_direction;
        bit seen;
        do_reset();
        start = 1'b1;
        wait_move(seen);
        dir = 2'd3; dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
        wait_move(seen);
        total++; if (!seen || head_x !== 5'd18 || head_y !== 5'd16) begin
            bad++; $display("FAIL dir_reversal got seen=%b head=%0d,%0d want 1 18,16", seen, head_x, head_y);
        end
        dir = 2'd0; dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
        wait_move(seen);
        total++; if (!seen || head_x !== 5'd18 || head_y !== 5'd15) begin
            bad++; $display("FAIL dir_up got seen=%b head=%0d,%0d want 1 18,15", seen, head_x, head_y);
        end
        repeat (3) @(negedge clk);
        dir = 2'd1; dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
        total++; if (shift_snake !== 1'b1 || head_x !== 5'd19 || head_y !== 5'd15) begin
            bad++; $display("FAIL dir_same_cycle got shift=%b head=%0d,%0d want 1 19,15", shift_snake, head_x, head_y);
        end
    endtask

    task automatic test_wrap;
        bit seen;
        int miss;
        miss = 0;
        do_reset();
        start = 1'b1;
        for (int i = 0; i < 15; i++) begin wait_move(seen); if (!seen) miss++; end
        total++; if (head_x !== 5'd31) begin bad++; $display("FAIL wrap_pre_x got=%0d want=31", head_x); end
        wait_move(seen); if (!seen) miss++;
        total++; if (head_x !== 5'd0 || head_y !== 5'd16) begin
            bad++; $display("FAIL wrap_x got head=%0d,%0d want 0,16", head_x, head_y);
        end
        dir = 2'd0; dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin wait_move(seen); if (!seen) miss++; end
        total++; if (head_x !== 5'd0 || head_y !== 5'd0) begin
            bad++; $display("FAIL wrap_pre_y got head=%0d,%0d want 0,0", head_x, head_y);
        end
        wait_move(seen); if (!seen) miss++;
        total++; if (head_x !== 5'd0 || head_y !== 5'd31) begin
            bad++; $display("FAIL wrap_y got head=%0d,%0d want 0,31", head_x, head_y);
        end
        total++; if (miss !== 0 || length !== 7'd3) begin
            bad++; $display("FAIL wrap_moves got missed=%0d len=%0d want 0 3", miss, length);
        end
    endtask

    task automatic test_growth;
        bit seen;
        do_reset();
        start = 1'b1;
        wait_move(seen);
        point = 1'b1; @(negedge clk); point = 1'b0; @(negedge clk);
        point = 1'b1; @(negedge clk); point = 1'b0;
        wait_move(seen);
        total++; if (!seen || length !== 7'd4 || tail_x !== 5'd15 || head_x !== 5'd18) begin
            bad++; $display("FAIL grow_move got seen=%b len=%0d tail=%0d head=%0d want 1 4 15 18", seen, length, tail_x, head_x);
        end
        wait_move(seen);
        total++; if (!seen || length !== 7'd4 || tail_x !== 5'd16 || head_x !== 5'd19) begin
            bad++; $display("FAIL grow_saturate_pending got seen=%b len=%0d tail=%0d head=%0d want 1 4 16 19", seen, length, tail_x, head_x);
        end
        repeat (3) @(negedge clk);
        point = 1'b1;
        @(negedge clk);
        point = 1'b0;
        total++; if (shift_snake !== 1'b1 || length !== 7'd5 || tail_x !== 5'd16 || head_x !== 5'd20) begin
            bad++; $display("FAIL grow_coincident got shift=%b len=%0d tail=%0d head=%0d want 1 5 16 20", shift_snake, length, tail_x, head_x);
        end
        wait_move(seen);
        total++; if (!seen || length !== 7'd5 || tail_x !== 5'd17) begin
            bad++; $display("FAIL grow_after got seen=%b len=%0d tail=%0d want 1 5 17", seen, length, tail_x);
        end
    endtask

    task automatic test_collision;
        bit seen;
        bit shifted;
        do_reset();
        start = 1'b1;
        wait_move(seen);
        point = 1'b1; @(negedge clk); point = 1'b0;
        wait_move(seen);
        point = 1'b1; @(negedge clk); point = 1'b0;
        wait_move(seen);
        total++; if (length !== 7'd5 || head_x !== 5'd19 || tail_x !== 5'd15) begin
            bad++; $display("FAIL coll_setup got len=%0d head=%0d tail=%0d want 5 19 15", length, head_x, tail_x);
        end
        dir = 2'd2; dir_valid = 1'b1; @(negedge clk); dir_valid = 1'b0;
        wait_move(seen);
        dir = 2'd3; dir_valid = 1'b1; @(negedge clk); dir_valid = 1'b0;
        wait_move(seen);
        total++; if (head_x !== 5'd18 || head_y !== 5'd17 || tail_x !== 5'd17 || tail_y !== 5'd16) begin
            bad++; $display("FAIL coll_turns got head=%0d,%0d tail=%0d,%0d want 18,17 17,16", head_x, head_y, tail_x, tail_y);
        end
        dir = 2'd0; dir_valid = 1'b1; @(negedge clk); dir_valid = 1'b0;
        shifted = 1'b0;
        for (int i = 0; i < 8 && !dead; i++) begin
            @(negedge clk);
            if (shift_snake) shifted = 1'b1;
        end
        total++; if (dead !== 1'b1 || shifted !== 1'b0) begin
            bad++; $display("FAIL coll_dead got dead=%b shift_seen=%b want 1 0", dead, shifted);
        end
        total++; if (head_x !== 5'd18 || head_y !== 5'd17 || length !== 7'd5 || tail_x !== 5'd17) begin
            bad++; $display("FAIL coll_frozen got head=%0d,%0d len=%0d tail=%0d want 18,17 5 17", head_x, head_y, length, tail_x);
        end
        shifted = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (shift_snake) shifted = 1'b1;
        end
        total++; if (dead !== 1'b1 || shifted !== 1'b0 || head_y !== 5'd17) begin
            bad++; $display("FAIL coll_stays got dead=%b shift_seen=%b head_y=%0d want 1 0 17", dead, shifted, head_y);
        end
        reset = 1'b0;
        #1;
        total++; if (dead !== 1'b0 || head_x !== 5'd16 || head_y !== 5'd16 || length !== 7'd3) begin
            bad++; $display("FAIL coll_reset got dead=%b head=%0d,%0d len=%0d want 0 16,16 3", dead, head_x, head_y, length);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_saturation;
        bit seen;
        do_reset();
        start = 1'b1; point = 1'b1;
        @(negedge clk);
        point = 1'b0;
        wait_move(seen);
        total++; if (s_length !== 3'd4 || s_tail_x !== 5'd14 || s_head_x !== 5'd17) begin
            bad++; $display("FAIL sat_move1 got len=%0d tail=%0d head=%0d want 4 14 17", s_length, s_tail_x, s_head_x);
        end
        point = 1'b1; @(negedge clk); point = 1'b0;
        wait_move(seen);
        total++; if (s_length !== 3'd4 || s_tail_x !== 5'd15) begin
            bad++; $display("FAIL sat_move2 got len=%0d tail=%0d want 4 15", s_length, s_tail_x);
        end
        point = 1'b1; @(negedge clk); point = 1'b0;
        wait_move(seen);
        total++; if (s_length !== 3'd4 || s_tail_x !== 5'd16 || s_head_x !== 5'd19 || s_dead !== 1'b0) begin
            bad++; $display("FAIL sat_move3 got len=%0d tail=%0d head=%0d dead=%b want 4 16 19 0", s_length, s_tail_x, s_head_x, s_dead);
        end
        query_x = 5'd18; query_y = 5'd16;
        @(negedge clk);
        total++; if (s_query_hit !== 1'b1) begin bad++; $display("FAIL sat_query got=%b want=1", s_query_hit); end
    endtask

    task automatic test_reset_mid;
        bit seen;
        bit shifted;
        do_reset();
        start = 1'b1;
        wait_move(seen);
        wait_move(seen);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        total++; if (head_x !== 5'd16 || head_y !== 5'd16 || tail_x !== 5'd14 || length !== 7'd3) begin
            bad++; $display("FAIL mid_reset got head=%0d,%0d tail=%0d len=%0d want 16,16 14 3", head_x, head_y, tail_x, length);
        end
        total++; if (shift_snake !== 1'b0 || dead !== 1'b0) begin
            bad++; $display("FAIL mid_reset_flags got shift=%b dead=%b want 0 0", shift_snake, dead);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        shifted = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (shift_snake) shifted = 1'b1;
        end
        total++; if (shifted !== 1'b0 || head_x !== 5'd16) begin
            bad++; $display("FAIL mid_reset_idle got shift_seen=%b head=%0d want 0 16", shifted, head_x);
        end
    endtask

    initial begin
        test_reset();
        test_query();
        test_run();
        test_direction();
        test_wrap();
        test_growth();
        test_collision();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
